// File: rtl/mdu_pkg.sv
// Shared types and sizing for the multiply/divide unit's shift-add multiplier.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;
  localparam int COUNT_W   = $clog2(MDU_WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } mdu_state_e;

endpackage

// File: rtl/mdu_shift_add_step.sv
// One shift-add iteration: conditional add of the multiplicand into the upper accumulator half,
// then shift {carry, acc} and the multiplier right by one. Purely combinational, no backpressure.
module mdu_shift_add_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   mplier_i,
  input  logic [WIDTH-1:0]   mcand_i,
  output logic [2*WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0]   mplier_o
);

  logic [WIDTH:0]   addend;
  logic [WIDTH:0]   upper_sum;
  logic [2*WIDTH:0] wide_acc;

  always_comb begin
    addend    = mplier_i[0] ? {1'b0, mcand_i} : '0;
    upper_sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + addend;
    // The carry out of the upper half becomes the new MSB after the shift.
    wide_acc  = {upper_sum, acc_i[WIDTH-1:0]};
    acc_o     = wide_acc[2*WIDTH:1];
    mplier_o  = {1'b0, mplier_i[WIDTH-1:1]};
  end

endmodule

// File: rtl/mdu_multiplier.sv
// Multi-cycle WIDTHxWIDTH shift-add multiplier with HI/LO; start at E0 gives done between E33 and E34.
// busy covers RUN/FIX; start is ignored unless IDLE, MTHI/MTLO are dropped while busy.
module mdu_multiplier
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  mdu_state_e         state_q;
  logic [CNT_W-1:0]   count_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH-1:0]   mplier_q;
  logic [WIDTH-1:0]   mplier_d;
  logic [WIDTH-1:0]   mcand_q;
  logic               neg_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] product;
  logic               mt_ok;

  mdu_shift_add_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .acc_i    (acc_q),
    .mplier_i (mplier_q),
    .mcand_i  (mcand_q),
    .acc_o    (acc_d),
    .mplier_o (mplier_d)
  );

  // Negating the most negative value yields itself, which is the correct unsigned magnitude.
  always_comb begin
    a_mag   = (is_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    b_mag   = (is_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
    product = neg_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;
    mt_ok   = (state_q == ST_IDLE) || (state_q == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      mcand_q  <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      if (mt_ok && hi_we) hi_q <= wdata;
      if (mt_ok && lo_we) lo_q <= wdata;

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            mcand_q  <= a_mag;
            mplier_q <= b_mag;
            neg_q    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc_q    <= '0;
            count_q  <= '0;
            state_q  <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc_q    <= acc_d;
          mplier_q <= mplier_d;
          count_q  <= count_q + 1'b1;
          if (count_q == CNT_W'(WIDTH - 1)) state_q <= ST_FIX;
        end
        ST_FIX: begin
          hi_q    <= product[2*WIDTH-1:WIDTH];
          lo_q    <= product[WIDTH-1:0];
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy = (state_q == ST_RUN) || (state_q == ST_FIX);
  assign done = (state_q == ST_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_multiplier.sv
// Directed bench for mdu_multiplier: expected products queued at issue, compared at done.
module tb_mdu_multiplier;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         is_signed;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         hi_we;
  logic         lo_we;
  logic [W-1:0] wdata;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_assert = 0;
  int n_fail   = 0;
  logic [2*W-1:0] sb_q[$];

  always #5 clk = ~clk;

  mdu_multiplier #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .hi_we     (hi_we),
    .lo_we     (lo_we),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model(input logic s, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx;
    logic signed [63:0] sy;
    if (s) begin
      sx = {{32{x[31]}}, x};
      sy = {{32{y[31]}}, y};
      return sx * sy;
    end
    return {32'b0, x} * {32'b0, y};
  endfunction

  // Drives start across edge E0 and queues the expected product.
  task automatic issue(input logic s, input logic [31:0] x, input logic [31:0] y);
    is_signed = s;
    a         = x;
    b         = y;
    start     = 1'b1;
    sb_q.push_back(model(s, x, y));
    tick;
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'(1));
  endtask

  task automatic wait_done(input int exp_n);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      tick;
      n++;
    end
    chk("done_latency", 64'(n), 64'(exp_n));
  endtask

  task automatic check_result(input string tag);
    logic [63:0] e;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_underflow"}, 64'(sb_q.size()), 64'(1));
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_hi"}, 64'(hi), 64'(e[63:32]));
      chk({tag, "_lo"}, 64'(lo), 64'(e[31:0]));
    end
  endtask

  task automatic run_op(input string tag, input logic s, input logic [31:0] x, input logic [31:0] y);
    issue(s, x, y);
    wait_done(33);
    check_result(tag);
    chk({tag, "_busy_in_done"}, 64'(busy), 64'(0));
    tick;
    chk({tag, "_done_one_cycle"}, 64'(done), 64'(0));
  endtask

  initial begin
    int pulses;
    logic [31:0] rx;
    logic [31:0] ry;

    reset = 1'b1; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    tick;
    tick;
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_done", 64'(done), 64'(0));
    chk("reset_hi", 64'(hi), 64'(0));
    chk("reset_lo", 64'(lo), 64'(0));
    reset = 1'b0;
    tick;

    // Basic product plus busy held through the whole run.
    issue(1'b0, 32'd7, 32'd6);
    for (int i = 1; i <= 32; i++) begin
      tick;
      chk("busy_during_run", 64'(busy), 64'(1));
    end
    tick;
    chk("done_at_e33", 64'(done), 64'(1));
    check_result("multu_7x6");
    tick;
    chk("done_cleared", 64'(done), 64'(0));

    run_op("multu_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mult_m1x1", 1'b1, 32'hFFFF_FFFF, 32'h0000_0001);
    run_op("mult_minxmin", 1'b1, 32'h8000_0000, 32'h8000_0000);
    run_op("mult_neg_pos", 1'b1, 32'hFFFF_FFF9, 32'd1000);
    run_op("multu_min", 1'b0, 32'h8000_0000, 32'h8000_0000);

    // A second start while running must be ignored.
    issue(1'b0, 32'd3, 32'd5);
    repeat (4) tick;
    is_signed = 1'b1; a = 32'd100; b = 32'hFFFF_FFFF; start = 1'b1;
    tick;
    start = 1'b0;
    wait_done(28);
    check_result("start_ignored");
    pulses = 1;
    for (int i = 0; i < 40; i++) begin
      tick;
      if (done === 1'b1) pulses++;
    end
    chk("done_once", 64'(pulses), 64'(1));

    // MTHI while busy is dropped.
    issue(1'b0, 32'd2, 32'd3);
    repeat (9) tick;
    hi_we = 1'b1; wdata = 32'h1234_5678;
    tick;
    hi_we = 1'b0;
    wait_done(23);
    check_result("mt_dropped");
    tick;
    hi_we = 1'b1; wdata = 32'h1234_5678;
    tick;
    hi_we = 1'b0;
    chk("mthi_idle_hi", 64'(hi), 64'h1234_5678);
    chk("mthi_idle_lo", 64'(lo), 64'd6);
    lo_we = 1'b1; wdata = 32'hCAFE_F00D;
    tick;
    lo_we = 1'b0;
    chk("mtlo_idle_hi", 64'(hi), 64'h1234_5678);
    chk("mtlo_idle_lo", 64'(lo), 64'hCAFE_F00D);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0BAD_BEEF;
    tick;
    hi_we = 1'b0; lo_we = 1'b0;
    chk("mt_both_hi", 64'(hi), 64'h0BAD_BEEF);
    chk("mt_both_lo", 64'(lo), 64'h0BAD_BEEF);

    // MT with start in the same cycle lands, then the product overwrites it.
    hi_we = 1'b1; wdata = 32'hAAAA_5555;
    issue(1'b0, 32'd4, 32'd5);
    hi_we = 1'b0;
    chk("mt_with_start_hi", 64'(hi), 64'hAAAA_5555);
    wait_done(33);
    check_result("mt_with_start");

    // MT in DONE wins over the held product.
    lo_we = 1'b1; wdata = 32'h0000_DEAD;
    tick;
    lo_we = 1'b0;
    chk("mt_in_done_lo", 64'(lo), 64'h0000_DEAD);
    chk("mt_in_done_hi", 64'(hi), 64'd0);

    // Reset mid-run abandons the operation.
    issue(1'b1, 32'hFFFF_FFFB, 32'd7);
    repeat (9) tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    void'(sb_q.pop_back());
    chk("midreset_busy", 64'(busy), 64'(0));
    chk("midreset_done", 64'(done), 64'(0));
    chk("midreset_hi", 64'(hi), 64'(0));
    chk("midreset_lo", 64'(lo), 64'(0));
    run_op("after_reset", 1'b1, 32'hFFFF_FFFB, 32'd7);

    for (int i = 0; i < 6; i++) begin
      rx = $urandom;
      ry = $urandom;
      run_op("random", 1'(i % 2), rx, ry);
    end

    chk("scoreboard_empty", 64'(sb_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
